aes_prng_clear_sched: RTL and testbench
=======================================

# aes_prng_clear_sched

Scheduler that shares the AES clearing PRNG among multiple clearing consumers and sequences its reseeding. It sits between the AES control/cipher-core clearing requesters and the clearing PRNG's data and reseed handshakes. It grants PRNG words round-robin and keeps data and reseed requests mutually exclusive. It reseeds the PRNG on explicit request or, optionally, after a fixed number of consumed words.

## Interface
- NumReq, 3, number of clearing requesters (key, state, output registers)
- CntW, 16, width of words-since-reseed counter
- ReseedInterval, 1024, words consumed before automatic reseed (auto-reseed build only); must be ≥1 and < 2^CntW
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- req_i  in  NumReq  requester i wants one clearing word; held high until its ack
- ack_o  out  NumReq  one-hot; PRNG word valid for requester i this cycle
- prng_data_req_o  out  1  data request to clearing PRNG
- prng_data_ack_i  in  1  PRNG data acknowledge (same-cycle response)
- reseed_req_i  in  1  explicit reseed request; level, held until reseed_ack_o
- reseed_ack_o  out  1  one-cycle pulse: explicit reseed completed
- prng_reseed_req_o  out  1  reseed request to clearing PRNG
- prng_reseed_ack_i  in  1  PRNG reseed done
- busy_o  out  1  state ≠ Idle
- words_o  out  CntW  words granted since last reseed, saturating

## Operation
- FSM states: Idle, Grant, Reseed.
- Idle:
  - reseed pending (reseed_req_i, or auto_due) → Reseed.
  - Else any req_i → latch round-robin pick into grant_q → Grant.
  - Else stay.
- Grant:
  - prng_data_req_o=1.
  - ack_o[grant_q] = prng_data_ack_i & req_i[grant_q].
  - On ack: rr pointer ← grant_q+1 mod NumReq; words counter +1, saturating → Idle.
  - If req_i[grant_q] falls without ack (protocol violation, asserted): → Idle, pointer unchanged.
- Reseed:
  - prng_reseed_req_o=1.
  - On prng_reseed_ack_i: counter ← 0; reseed_ack_o = reseed_req_i in that same cycle → Idle.
  - An auto reseed also satisfies a concurrently held explicit request.
- Round-robin: lowest index ≥ pointer with req set, wrapping; pointer resets to 0.
- prng_data_req_o and prng_reseed_req_o are never high in the same cycle.
- No preemption: a reseed request arriving during Grant waits until that grant completes.

## Timing
- Reset values: all outputs 0, words_o=0, state Idle, pointer 0, grant_q 0.
- Reset mid-grant or mid-reseed: all requests drop on the next edge; any in-flight word or reseed is abandoned.
- Data latency: req_i high in Idle at cycle n → prng_data_req_o at n+1 → ack_o at n+1 earliest (PRNG acks same cycle). Peak throughput is one word per 2 cycles.
- Reseed latency: Idle → prng_reseed_req_o the next cycle, held until ack. reseed_ack_o is combinational with prng_reseed_ack_i.
- Simultaneous reseed and data requests in Idle: reseed wins.
- Counter saturates at 2^CntW−1; words_o is the registered counter.

## Configuration
- AES_PRNG_CLEAR_SCHED_AUTO_RESEED_EN defined:
  - auto_due = (counter ≥ ReseedInterval).
  - Triggers Reseed from Idle with reseed_ack_o low, unless reseed_req_i is also high.
- Undefined:
  - auto_due tied 0; only explicit reseeds occur.
  - Counter still runs for words_o; ReseedInterval is unused.

## Structure
- aes_pkg gains:
  - enum prng_sched_e {SchedIdle, SchedGrant, SchedReseed}, sparse-encoded per the FSM hardening rules, with an invalid-state default → Idle.
  - Constant default ReseedInterval.
- Sub-module aes_prng_clear_rr: combinational round-robin pick.
  - Inputs: req vector, pointer.
  - Outputs: index, valid.

## Test plan
- Single requester: req_i=3'b001 at cycle 1, PRNG acks immediately → prng_data_req_o at 2, ack_o=001 at 2, words_o=1 at 3.
- Fairness: req_i=111 held, PRNG always acks → ack_o sequence 001,010,100,001 on every second cycle.
- Reseed priority: reseed_req_i and req_i=010 both rise in Idle; PRNG reseed ack after 4 cycles → reseed completes and words_o=0 before any ack_o; reseed_ack_o is a single pulse.
- Reseed during grant: reseed_req_i rises while in Grant with prng_data_ack_i delayed 3 cycles → ack_o completes first, then prng_reseed_req_o; the two requests never overlap.
- Auto reseed (macro on, ReseedInterval=4): 4 acked words → prng_reseed_req_o asserted, reseed_ack_o stays 0, words_o returns to 0. Macro off: no reseed and words_o=4.
- Reset during Reseed: rst_i high for 1 cycle → next cycle all outputs 0 and words_o=0.

Source files
------------

// File: rtl/aes_prng_clear_sched_pkg.sv
// Shared types for the AES clearing-PRNG scheduler: hardened state encoding and default reseed interval.
// No logic, no latency, no backpressure.
// Referenced by aes_prng_clear_sched and aes_prng_clear_rr.
package aes_prng_clear_sched_pkg;

   // Pairwise Hamming distance >= 3 so a single upset never lands on another legal state.
   typedef enum logic [4:0] {
      SchedIdle   = 5'b01001,
      SchedGrant  = 5'b10100,
      SchedReseed = 5'b11111
   } prng_sched_e;

   localparam int unsigned ReseedIntervalDefault = 32'd1024;

endpackage

// File: rtl/aes_prng_clear_rr.sv
// Combinational round-robin pick: lowest requester index at or after ptr_i, wrapping.
// Zero latency; no backpressure (pure function of req_i and ptr_i).
// vld_o is low when no requester is active.
module aes_prng_clear_rr
   import aes_prng_clear_sched_pkg::*;
#(
   parameter int unsigned NumReq = 3,
   parameter int unsigned IdxW   = 2
) (
   input  logic [NumReq-1:0] req_i,
   input  logic [IdxW-1:0]   ptr_i,
   output logic [IdxW-1:0]   idx_o,
   output logic              vld_o
);

   // Scan from the farthest offset down so the nearest active requester wins.
   always_comb begin
      idx_o = '0;
      vld_o = 1'b0;
      for (int i = int'(NumReq) - 1; i >= 0; i--) begin
         if (req_i[IdxW'((int'(ptr_i) + i) % int'(NumReq))]) begin
            idx_o = IdxW'((int'(ptr_i) + i) % int'(NumReq));
            vld_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/aes_prng_clear_sched.sv
// Shares the AES clearing PRNG among NumReq consumers (round-robin words) and sequences reseeds.
// Latency: request in Idle -> prng_data_req_o next cycle; ack_o same cycle as prng_data_ack_i.
// Backpressure: req_i/reseed_req_i held until acked; AES_PRNG_CLEAR_SCHED_AUTO_RESEED_EN adds interval reseeds.
module aes_prng_clear_sched
   import aes_prng_clear_sched_pkg::*;
#(
   parameter int unsigned NumReq         = 3,
   parameter int unsigned CntW           = 16,
   parameter int unsigned ReseedInterval = ReseedIntervalDefault
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NumReq-1:0] req_i,
   output logic [NumReq-1:0] ack_o,
   output logic              prng_data_req_o,
   input  logic              prng_data_ack_i,
   input  logic              reseed_req_i,
   output logic              reseed_ack_o,
   output logic              prng_reseed_req_o,
   input  logic              prng_reseed_ack_i,
   output logic              busy_o,
   output logic [CntW-1:0]   words_o
);

   localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

`ifdef AES_PRNG_CLEAR_SCHED_AUTO_RESEED_EN
   localparam logic AutoReseedEn = 1'b1;
`else
   localparam logic AutoReseedEn = 1'b0;
`endif

   prng_sched_e       state_q, state_d;
   logic [IdxW-1:0]   ptr_q, ptr_d;
   logic [IdxW-1:0]   grant_q, grant_d;
   logic [CntW-1:0]   words_q, words_d;
   logic [IdxW-1:0]   rr_idx;
   logic              rr_vld;
   logic              auto_due;

   aes_prng_clear_rr #(
      .NumReq (NumReq),
      .IdxW   (IdxW)
   ) u_rr (
      .req_i  (req_i),
      .ptr_i  (ptr_q),
      .idx_o  (rr_idx),
      .vld_o  (rr_vld)
   );

   assign auto_due = AutoReseedEn & (32'(words_q) >= ReseedInterval);

   always_comb begin
      state_d           = state_q;
      ptr_d             = ptr_q;
      grant_d           = grant_q;
      words_d           = words_q;
      ack_o             = '0;
      prng_data_req_o   = 1'b0;
      prng_reseed_req_o = 1'b0;
      reseed_ack_o      = 1'b0;
      busy_o            = (state_q != SchedIdle);

      case (state_q)
         SchedIdle: begin
            if (reseed_req_i || auto_due) begin
               state_d = SchedReseed;
            end else if (rr_vld) begin
               grant_d = rr_idx;
               state_d = SchedGrant;
            end
         end
         SchedGrant: begin
            prng_data_req_o = 1'b1;
            if (!req_i[grant_q]) begin
               state_d = SchedIdle;
            end else if (prng_data_ack_i) begin
               ack_o[grant_q] = 1'b1;
               ptr_d          = (grant_q == IdxW'(NumReq - 1)) ? '0 : grant_q + 1'b1;
               words_d        = (&words_q) ? words_q : words_q + 1'b1;
               state_d        = SchedIdle;
            end
         end
         SchedReseed: begin
            prng_reseed_req_o = 1'b1;
            if (prng_reseed_ack_i) begin
               // An auto reseed also retires an explicit request held alongside it.
               reseed_ack_o = reseed_req_i;
               words_d      = '0;
               state_d      = SchedIdle;
            end
         end
         default: begin
            state_d = SchedIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= SchedIdle;
         ptr_q   <= '0;
         grant_q <= '0;
         words_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         words_q <= words_d;
      end
   end

   assign words_o = words_q;

   grant_req_held_a: assert property (@(posedge clk_i) disable iff (rst_i)
      (state_q == SchedGrant) |-> req_i[grant_q]);

endmodule

// File: tb/tb_aes_prng_clear_sched.sv
// Directed bench for aes_prng_clear_sched with a cycle-level reference model and literal pins.
// Honours AES_PRNG_CLEAR_SCHED_AUTO_RESEED_EN to select the expected auto-reseed behaviour.
module tb_aes_prng_clear_sched;

   localparam int NumReq   = 3;
   localparam int CntW     = 16;
   localparam int Interval = 4;
   localparam int CntMax   = (1 << CntW) - 1;

`ifdef AES_PRNG_CLEAR_SCHED_AUTO_RESEED_EN
   localparam bit AutoOn = 1'b1;
`else
   localparam bit AutoOn = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_i;
   logic [NumReq-1:0] req_i;
   logic [NumReq-1:0] ack_o;
   logic              prng_data_req_o;
   logic              prng_data_ack_i;
   logic              reseed_req_i;
   logic              reseed_ack_o;
   logic              prng_reseed_req_o;
   logic              prng_reseed_ack_i;
   logic              busy_o;
   logic [CntW-1:0]   words_o;

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Stimulus state: outstanding words per requester, PRNG response delays.
   int want [NumReq];
   bit rs_want, rst_want;
   int dlat, rlat, dcnt, rcnt;
   int cyc_no;
   logic [NumReq-1:0] s_ack;
   logic s_rack, s_dpend, s_rpend;

   assign prng_data_ack_i   = prng_data_req_o   && (dcnt >= dlat);
   assign prng_reseed_ack_i = prng_reseed_req_o && (rcnt >= rlat);

   aes_prng_clear_sched #(
      .NumReq         (NumReq),
      .CntW           (CntW),
      .ReseedInterval (Interval)
   ) dut (
      .clk_i             (clk),
      .rst_i             (rst_i),
      .req_i             (req_i),
      .ack_o             (ack_o),
      .prng_data_req_o   (prng_data_req_o),
      .prng_data_ack_i   (prng_data_ack_i),
      .reseed_req_i      (reseed_req_i),
      .reseed_ack_o      (reseed_ack_o),
      .prng_reseed_req_o (prng_reseed_req_o),
      .prng_reseed_ack_i (prng_reseed_ack_i),
      .busy_o            (busy_o),
      .words_o           (words_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_no);
      end
   endtask

   // Reference model: what the scheduler is doing (0 idle, 1 serving m_who, 2 reseeding).
   int m_mode = 0;
   int m_who  = 0;
   int m_ptr  = 0;
   int m_cnt  = 0;

   always @(negedge clk) begin
      logic [NumReq-1:0] e_ack;
      logic e_dreq, e_rreq, e_rack;
      bit   found;
      e_ack  = '0;
      e_dreq = 1'b0;
      e_rreq = 1'b0;
      e_rack = 1'b0;
      if (m_mode == 1) begin
         e_dreq = 1'b1;
         if (req_i[m_who] && prng_data_ack_i) e_ack[m_who] = 1'b1;
      end else if (m_mode == 2) begin
         e_rreq = 1'b1;
         if (prng_reseed_ack_i) e_rack = reseed_req_i;
      end
      check("ack_o", ack_o, e_ack);
      check("prng_data_req_o", prng_data_req_o, e_dreq);
      check("prng_reseed_req_o", prng_reseed_req_o, e_rreq);
      check("reseed_ack_o", reseed_ack_o, e_rack);
      check("busy_o", busy_o, m_mode != 0);
      check("words_o", words_o, m_cnt);
      check("req_exclusive", prng_data_req_o & prng_reseed_req_o, 0);

      if (rst_i) begin
         m_mode = 0; m_who = 0; m_ptr = 0; m_cnt = 0;
      end else if (m_mode == 0) begin
         if (reseed_req_i || (AutoOn && m_cnt >= Interval)) begin
            m_mode = 2;
         end else begin
            found = 1'b0;
            for (int k = 0; k < NumReq; k++) begin
               if (!found && req_i[(m_ptr + k) % NumReq]) begin
                  found = 1'b1;
                  m_who = (m_ptr + k) % NumReq;
               end
            end
            if (found) m_mode = 1;
         end
      end else if (m_mode == 1) begin
         if (!req_i[m_who]) begin
            m_mode = 0;
         end else if (prng_data_ack_i) begin
            m_ptr  = (m_who + 1) % NumReq;
            m_cnt  = (m_cnt < CntMax) ? m_cnt + 1 : m_cnt;
            m_mode = 0;
         end
      end else begin
         if (prng_reseed_ack_i) begin
            m_cnt  = 0;
            m_mode = 0;
         end
      end
   end

   // One clock: apply stimulus just after the edge, then sample at the falling edge.
   task automatic cyc();
      @(posedge clk);
      #1;
      for (int i = 0; i < NumReq; i++) if (s_ack[i] && want[i] > 0) want[i]--;
      if (s_rack) rs_want = 1'b0;
      dcnt = s_dpend ? dcnt + 1 : 0;
      rcnt = s_rpend ? rcnt + 1 : 0;
      rst_i        = rst_want;
      reseed_req_i = rs_want;
      for (int i = 0; i < NumReq; i++) req_i[i] = (want[i] > 0);
      @(negedge clk);
      s_ack   = ack_o;
      s_rack  = reseed_ack_o;
      s_dpend = prng_data_req_o && !prng_data_ack_i;
      s_rpend = prng_reseed_req_o && !prng_reseed_ack_i;
      cyc_no++;
   endtask

   task automatic do_reset();
      rst_want = 1'b1;
      rs_want  = 1'b0;
      for (int i = 0; i < NumReq; i++) want[i] = 0;
      dlat = 0;
      rlat = 0;
      cyc();
      rst_want = 1'b0;
      cyc();
   endtask

   int q_ack [$];
   int q_cyc [$];
   int ack_cyc, rack_cyc, rreq_cyc, rack_cnt, words_at_ack;
   logic [NumReq-1:0] first_ack;
   bit overlap, rreq_seen, rack_seen;

   initial begin
      rst_i = 1'b1; rst_want = 1'b1; req_i = '0; reseed_req_i = 1'b0; rs_want = 1'b0;
      for (int i = 0; i < NumReq; i++) want[i] = 0;
      dlat = 0; rlat = 0; dcnt = 0; rcnt = 0; cyc_no = 0;
      s_ack = '0; s_rack = 1'b0; s_dpend = 1'b0; s_rpend = 1'b0;
      cyc(); cyc();
      rst_want = 1'b0;
      cyc();
      check("reset_outputs", {ack_o, prng_data_req_o, prng_reseed_req_o, reseed_ack_o, busy_o}, 0);
      check("reset_words", words_o, 0);

      // Single requester, immediate PRNG ack.
      want[0] = 1;
      cyc();
      check("single_idle_busy", busy_o, 0);
      cyc();
      check("single_data_req", prng_data_req_o, 1);
      check("single_ack", ack_o, 3'b001);
      cyc();
      check("single_words", words_o, 1);
      check("single_back_idle", busy_o, 0);

      // Fairness with all three requesters held.
      do_reset();
      for (int i = 0; i < NumReq; i++) want[i] = 2;
      for (int n = 0; n < 10; n++) begin
         cyc();
         if (s_ack != 0) begin
            q_ack.push_back(int'(s_ack));
            q_cyc.push_back(cyc_no);
         end
      end
      check("fair_count_ge4", q_ack.size() >= 4, 1);
      if (q_ack.size() >= 4) begin
         check("fair_ack0", q_ack[0], 3'b001);
         check("fair_ack1", q_ack[1], 3'b010);
         check("fair_ack2", q_ack[2], 3'b100);
         check("fair_ack3", q_ack[3], 3'b001);
         for (int k = 1; k < 4; k++) check("fair_spacing", q_cyc[k] - q_cyc[k-1], 2);
      end

      // Reseed beats a simultaneous data request.
      do_reset();
      want[0] = 2;
      for (int n = 0; n < 6; n++) cyc();
      check("prio_words_before", words_o, 2);
      want[1] = 1; rs_want = 1'b1; rlat = 3;
      ack_cyc = -1; rack_cyc = -1; rack_cnt = 0; first_ack = '0; words_at_ack = -1;
      for (int n = 0; n < 20; n++) begin
         cyc();
         if (s_rack) begin
            rack_cnt++;
            if (rack_cyc < 0) rack_cyc = cyc_no;
         end
         if (s_ack != 0 && ack_cyc < 0) begin
            ack_cyc = cyc_no;
            first_ack = s_ack;
            words_at_ack = int'(words_o);
         end
      end
      check("prio_rack_pulses", rack_cnt, 1);
      check("prio_rack_first", (rack_cyc > 0) && (ack_cyc > rack_cyc), 1);
      check("prio_ack_who", first_ack, 3'b010);
      check("prio_words_at_ack", words_at_ack, 0);

      // Reseed request arriving during a slow grant waits for it.
      do_reset();
      dlat = 3; want[2] = 1;
      cyc(); cyc();
      check("dg_in_grant", prng_data_req_o, 1);
      rs_want = 1'b1;
      ack_cyc = -1; rreq_cyc = -1; overlap = 1'b0; first_ack = '0;
      for (int n = 0; n < 15; n++) begin
         cyc();
         if (prng_data_req_o && prng_reseed_req_o) overlap = 1'b1;
         if (s_ack != 0 && ack_cyc < 0) begin
            ack_cyc = cyc_no;
            first_ack = s_ack;
         end
         if (prng_reseed_req_o && rreq_cyc < 0) rreq_cyc = cyc_no;
      end
      check("dg_ack_who", first_ack, 3'b100);
      check("dg_order", (ack_cyc > 0) && (rreq_cyc > ack_cyc), 1);
      check("dg_no_overlap", overlap, 0);

      // Auto reseed after Interval words (only when the feature is built in).
      do_reset();
      rlat = 1; want[0] = Interval;
      rreq_seen = 1'b0; rack_seen = 1'b0;
      for (int n = 0; n < 16; n++) begin
         cyc();
         if (prng_reseed_req_o) rreq_seen = 1'b1;
         if (reseed_ack_o) rack_seen = 1'b1;
      end
      check("auto_reseed_req", rreq_seen, AutoOn);
      check("auto_reseed_ack", rack_seen, 0);
      check("auto_words", words_o, AutoOn ? 0 : Interval);

      // Reset while a reseed is outstanding.
      do_reset();
      want[1] = 1;
      for (int n = 0; n < 4; n++) cyc();
      rs_want = 1'b1; rlat = 50;
      rreq_seen = 1'b0;
      for (int n = 0; n < 6; n++) begin
         cyc();
         if (prng_reseed_req_o) rreq_seen = 1'b1;
      end
      check("rst_reseed_active", rreq_seen, 1);
      check("rst_words_before", words_o, 1);
      do_reset();
      check("rst_outputs", {ack_o, prng_data_req_o, prng_reseed_req_o, reseed_ack_o, busy_o}, 0);
      check("rst_words", words_o, 0);
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
